param_insertion_sorter: RTL and testbench

PARAM_INSERTION_SORTER -- requirements
Module: param_insertion_sorter

---
 rtl/param_insertion_sorter_if.sv | 32 +++
 rtl/param_insertion_sorter.sv | 184 ++++++++++++++++++
 tb/tb_param_insertion_sorter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_insertion_sorter_if.sv
// Handshake, data and status bundle for param_insertion_sorter.
// The sorter connects through the slave modport; the producer/consumer side uses master.
interface param_insertion_sorter_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_key;
    logic [TAG_W-1:0] in_tag;
    logic             descending;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_key;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             draining;

    modport master (
        output in_valid, in_key, in_tag, descending, flush, out_ready,
        input  in_ready, out_valid, out_key, out_tag, count, full, empty, draining
    );

    modport slave (
        input  in_valid, in_key, in_tag, descending, flush, out_ready,
        output in_ready, out_valid, out_key, out_tag, count, full, empty, draining
    );
endinterface

// File: rtl/param_insertion_sorter.sv
// Systolic-style insertion sorter: keys are placed in sorted position on entry and drained head-first.
// Define SORTER_TAG_EN to build tag storage so in_tag travels with its key to out_tag.
module param_insertion_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    nreset,
    param_insertion_sorter_if.slave bus
);
    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_key_q, out_key_d;
    logic [WIDTH-1:0] key_q [DEPTH];
    logic [WIDTH-1:0] key_d [DEPTH];
    logic [DEPTH-1:0] take;
    logic             full;
    logic             empty;
    logic             do_insert;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // take[i]: cell i is at or behind the insert position; strict compare keeps equal keys in arrival order
    always_comb begin
        take = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) >= count_q) begin
                take[i] = 1'b1;
            end else if (dir_q) begin
                take[i] = (key_q[i] < bus.in_key);
            end else begin
                take[i] = (key_q[i] > bus.in_key);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dir_d     = dir_q;
        do_insert = 1'b0;
        do_pop    = 1'b0;
        case (state_q)
            FILL: begin
                do_insert = bus.in_valid && !full;
                if (do_insert) begin
                    count_d = count_q + 1'b1;
                    if (empty) begin
                        dir_d = bus.descending;
                    end
                end
                if (bus.flush && (count_d != '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                do_pop = out_valid_q && bus.out_ready;
                if (do_pop) begin
                    count_d = count_q - 1'b1;
                end
                if (count_d == '0) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i] = key_q[i];
        end
        if (do_insert) begin
            if (take[0]) begin
                key_d[0] = bus.in_key;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (take[i]) begin
                    key_d[i] = take[i-1] ? key_q[i-1] : bus.in_key;
                end
            end
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                key_d[i] = key_q[i+1];
            end
            key_d[DEPTH-1] = '0;
        end
    end

    // Output register tracks the next head while draining and otherwise holds its last value
    always_comb begin
        out_valid_d = (state_d == DRAIN) && (count_d != '0);
        out_key_d   = out_valid_d ? key_d[0] : out_key_q;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= FILL;
            count_q     <= '0;
            dir_q       <= bus.descending;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i] <= key_d[i];
            end
        end
    end

`ifdef SORTER_TAG_EN
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // Tags shift exactly like their keys, using the same position vector
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i];
        end
        if (do_insert) begin
            if (take[0]) begin
                tag_d[0] = bus.in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (take[i]) begin
                    tag_d[i] = take[i-1] ? tag_q[i-1] : bus.in_tag;
                end
            end
        end else if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                tag_d[i] = tag_q[i+1];
            end
            tag_d[DEPTH-1] = '0;
        end
        out_tag_d = out_valid_d ? tag_d[0] : out_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_tag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            out_tag_q <= out_tag_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign bus.out_tag = out_tag_q;
`else
    logic unused_tag;
    assign unused_tag  = ^bus.in_tag;
    assign bus.out_tag = '0;
`endif

    assign bus.in_ready  = (state_q == FILL) && !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_key   = out_key_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.draining  = (state_q == DRAIN);
endmodule

// File: tb/tb_param_insertion_sorter.sv
// Directed self-checking bench for param_insertion_sorter at default parameters.
// Tag expectations collapse to zero unless SORTER_TAG_EN is defined.
module tb_param_insertion_sorter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 28;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    param_insertion_sorter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

    param_insertion_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [TAG_W-1:0] exp_tag(input logic [TAG_W-1:0] t);
`ifdef SORTER_TAG_EN
        return t;
`else
        return t & {TAG_W{1'b0}};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_key(input logic [WIDTH-1:0] k, input logic [TAG_W-1:0] t);
        bus.in_valid = 1'b1;
        bus.in_key   = k;
        bus.in_tag   = t;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.count !== CNT_W'(0) || bus.in_ready !== 1'b1 || bus.empty !== 1'b1 ||
            bus.full !== 1'b0 || bus.draining !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got count=%0d rdy=%b empty=%b full=%b drain=%b ov=%b expected 0 1 1 0 0 0",
                     bus.count, bus.in_ready, bus.empty, bus.full, bus.draining, bus.out_valid);
        end
        vectors++;
        if (bus.out_key !== 8'd0 || bus.out_tag !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got key=%0d tag=%0d expected 0 0", bus.out_key, bus.out_tag);
        end
        nreset = 1'b1;
        tick();
        pulse_flush();
        vectors++;
        if (bus.draining !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL empty_flush: got drain=%b ov=%b rdy=%b expected 0 0 1",
                     bus.draining, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_descending();
        logic [WIDTH-1:0] keys  [5] = '{8'd5, 8'd200, 8'd17, 8'd200, 8'd0};
        logic [WIDTH-1:0] exp_k [5] = '{8'd200, 8'd200, 8'd17, 8'd5, 8'd0};
        logic [TAG_W-1:0] exp_t [5] = '{4'd2, 4'd4, 4'd3, 4'd1, 4'd5};
        bus.descending = 1'b1;
        for (int i = 0; i < 5; i++) insert_key(keys[i], 4'(i + 1));
        vectors++;
        if (bus.count !== CNT_W'(5)) begin
            miscompares++;
            $display("[TB] FAIL desc_count: got %0d expected 5", bus.count);
        end
        bus.out_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_key !== exp_k[i] || bus.out_tag !== exp_tag(exp_t[i])) begin
                miscompares++;
                $display("[TB] FAIL desc_pop%0d: got ov=%b key=%0d tag=%0d expected 1 %0d %0d",
                         i, bus.out_valid, bus.out_key, bus.out_tag, exp_k[i], exp_tag(exp_t[i]));
            end
            tick();
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1 || bus.draining !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL desc_done: got ov=%b empty=%b rdy=%b drain=%b expected 0 1 1 0",
                     bus.out_valid, bus.empty, bus.in_ready, bus.draining);
        end
    endtask

    task automatic test_ascending_tags();
        logic [WIDTH-1:0] keys  [4] = '{8'd9, 8'd3, 8'd3, 8'd250};
        logic [WIDTH-1:0] exp_k [4] = '{8'd3, 8'd3, 8'd9, 8'd250};
        logic [TAG_W-1:0] exp_t [4] = '{4'd2, 4'd3, 4'd1, 4'd4};
        bus.descending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            insert_key(keys[i], 4'(i + 1));
            bus.descending = 1'b1;
        end
        bus.out_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_key !== exp_k[i] || bus.out_tag !== exp_tag(exp_t[i])) begin
                miscompares++;
                $display("[TB] FAIL asc_pop%0d: got ov=%b key=%0d tag=%0d expected 1 %0d %0d",
                         i, bus.out_valid, bus.out_key, bus.out_tag, exp_k[i], exp_tag(exp_t[i]));
            end
            tick();
        end
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_key !== 8'd250) begin
            miscompares++;
            $display("[TB] FAIL asc_hold: got ov=%b key=%0d expected 0 250", bus.out_valid, bus.out_key);
        end
    endtask

    task automatic test_full();
        bus.descending = 1'b1;
        for (int i = 0; i < DEPTH; i++) insert_key(8'(27 - i), 4'(i));
        vectors++;
        if (bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.count !== CNT_W'(DEPTH)) begin
            miscompares++;
            $display("[TB] FAIL full_flags: got full=%b rdy=%b count=%0d expected 1 0 28",
                     bus.full, bus.in_ready, bus.count);
        end
        insert_key(8'd99, 4'd15);
        vectors++;
        if (bus.count !== CNT_W'(DEPTH) || bus.full !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_reject: got count=%0d full=%b expected 28 1", bus.count, bus.full);
        end
        bus.out_ready = 1'b1;
        pulse_flush();
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_key !== 8'(27 - i) || bus.out_tag !== exp_tag(4'(i))) begin
                miscompares++;
                $display("[TB] FAIL full_pop%0d: got ov=%b key=%0d tag=%0d expected 1 %0d %0d",
                         i, bus.out_valid, bus.out_key, bus.out_tag, 27 - i, exp_tag(4'(i)));
            end
            tick();
        end
        vectors++;
        if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_done: got empty=%b ov=%b expected 1 0", bus.empty, bus.out_valid);
        end
    endtask

    task automatic test_flush_with_insert();
        logic [WIDTH-1:0] exp_k [3] = '{8'd8, 8'd6, 8'd4};
        bus.descending = 1'b1;
        bus.out_ready  = 1'b1;
        insert_key(8'd4, 4'd1);
        insert_key(8'd8, 4'd2);
        bus.flush = 1'b1;
        insert_key(8'd6, 4'd3);
        bus.flush = 1'b0;
        vectors++;
        if (bus.draining !== 1'b1 || bus.count !== CNT_W'(3)) begin
            miscompares++;
            $display("[TB] FAIL flush_ins: got drain=%b count=%0d expected 1 3", bus.draining, bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_key !== exp_k[i]) begin
                miscompares++;
                $display("[TB] FAIL flush_pop%0d: got ov=%b key=%0d expected 1 %0d",
                         i, bus.out_valid, bus.out_key, exp_k[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        bus.descending = 1'b1;
        bus.out_ready  = 1'b1;
        insert_key(8'd30, 4'd1);
        insert_key(8'd10, 4'd2);
        insert_key(8'd20, 4'd3);
        pulse_flush();
        vectors++;
        if (bus.out_key !== 8'd30 || bus.count !== CNT_W'(3)) begin
            miscompares++;
            $display("[TB] FAIL stall_head: got key=%0d count=%0d expected 30 3", bus.out_key, bus.count);
        end
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_key !== 8'd20 || bus.count !== CNT_W'(2)) begin
                miscompares++;
                $display("[TB] FAIL stall_hold%0d: got ov=%b key=%0d count=%0d expected 1 20 2",
                         i, bus.out_valid, bus.out_key, bus.count);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_key !== 8'd10 || bus.count !== CNT_W'(1)) begin
            miscompares++;
            $display("[TB] FAIL stall_resume: got ov=%b key=%0d count=%0d expected 1 10 1",
                     bus.out_valid, bus.out_key, bus.count);
        end
        tick();
        vectors++;
        if (bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_done: got empty=%b rdy=%b expected 1 1", bus.empty, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_drain();
        bus.descending = 1'b1;
        bus.out_ready  = 1'b0;
        for (int i = 0; i < 10; i++) insert_key(8'(i * 3 + 1), 4'(i));
        pulse_flush();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.count !== CNT_W'(10) || bus.out_key !== 8'd28) begin
            miscompares++;
            $display("[TB] FAIL rst_pre: got ov=%b count=%0d key=%0d expected 1 10 28",
                     bus.out_valid, bus.count, bus.out_key);
        end
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        vectors++;
        if (bus.count !== CNT_W'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.draining !== 1'b0 || bus.out_key !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid: got count=%0d ov=%b rdy=%b drain=%b key=%0d expected 0 0 1 0 0",
                     bus.count, bus.out_valid, bus.in_ready, bus.draining, bus.out_key);
        end
        bus.out_ready = 1'b1;
        pulse_flush();
        tick();
        vectors++;
        if (bus.draining !== 1'b0 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_flush: got drain=%b ov=%b empty=%b expected 0 0 1",
                     bus.draining, bus.out_valid, bus.empty);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_key     = '0;
        bus.in_tag     = '0;
        bus.descending = 1'b1;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_descending();
        test_ascending_tags();
        test_full();
        test_flush_with_insert();
        test_stall();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
